// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: accepts one load/store, waits LATENCY cycles,
// performs the byte-enabled word access, and holds the response until it is taken.
module dmem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy
);

    localparam int         AW        = $clog2(DEPTH_WORDS);
    localparam logic [29:0] DEPTH_LIM = 30'(DEPTH_WORDS);
    localparam logic [3:0]  LAT_INIT  = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic [31:0] mem [DEPTH_WORDS];

    logic        access_en;
    logic        acc_we;
    logic [31:0] acc_addr;
    logic [31:0] acc_wdata;
    logic [3:0]  acc_be;
    logic        acc_err;
    logic [AW-1:0] word_idx;
    logic        wr_en;

    // With zero latency the access happens on the accept edge, so it must use the live request.
    always_comb begin
        if (state_q == IDLE) begin
            acc_we    = req_we;
            acc_addr  = req_addr;
            acc_wdata = req_wdata;
            acc_be    = req_be;
        end else begin
            acc_we    = we_q;
            acc_addr  = addr_q;
            acc_wdata = wdata_q;
            acc_be    = be_q;
        end
        acc_err  = (acc_addr[1:0] != 2'b00) || (acc_addr[31:2] >= DEPTH_LIM);
        word_idx = acc_addr[AW+1:2];
        wr_en    = access_en && acc_we && !acc_err;
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        be_d      = be_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        access_en = 1'b0;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    be_d    = req_be;
                    if (LATENCY == 0) begin
                        access_en = 1'b1;
                        state_d   = RESP;
                    end else begin
                        cnt_d   = LAT_INIT;
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    access_en = 1'b1;
                    state_d   = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                    rdata_d = 32'd0;
                    err_d   = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        if (access_en) begin
            err_d   = acc_err;
            rdata_d = (acc_we || acc_err) ? 32'd0 : mem[word_idx];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            be_q    <= 4'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Storage is deliberately outside the reset domain so committed data survives a reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < 4; i++) begin
                if (acc_be[i]) begin
                    mem[word_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
                end
            end
        end
    end

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == RESP);
    assign busy      = (state_q != IDLE);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: transaction-level reference model,
// per-cycle output comparison, directed scenarios and a randomized phase.
module tb_dmem_responder;

    localparam int LAT   = 2;
    localparam int DEPTH = 256;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0, req_we = 1'b0, rsp_ready = 1'b1;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic [3:0]  req_be = '0;
    logic        req_ready, rsp_valid, rsp_err, busy;
    logic [31:0] rsp_rdata;

    logic        l0_req_valid = 1'b0, l0_req_we = 1'b0, l0_rsp_ready = 1'b1;
    logic [31:0] l0_req_addr = '0, l0_req_wdata = '0;
    logic [3:0]  l0_req_be = '0;
    logic        l0_req_ready, l0_rsp_valid, l0_rsp_err, l0_busy;
    logic [31:0] l0_rsp_rdata;

    int n_cmp = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) u_dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .busy(busy)
    );

    dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(0)) u_lat0 (
        .clk(clk), .reset(reset),
        .req_valid(l0_req_valid), .req_ready(l0_req_ready), .req_we(l0_req_we),
        .req_addr(l0_req_addr), .req_wdata(l0_req_wdata), .req_be(l0_req_be),
        .rsp_valid(l0_rsp_valid), .rsp_ready(l0_rsp_ready), .rsp_rdata(l0_rsp_rdata),
        .rsp_err(l0_rsp_err), .busy(l0_busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_fail++;
        $display("[TB] FAIL %s: bound expired at %0t", name, $time);
    endtask

    // Reference model: one outstanding transaction, visible after LAT edges past acceptance.
    logic [31:0] m_mem [DEPTH];
    bit          m_pend = 1'b0;
    int          m_age = 0;
    bit          m_we, m_err;
    logic [31:0] m_addr, m_wdata, m_rdata;
    logic [3:0]  m_be;
    int          m_accepts = 0;
    int          m_dones = 0;

    function automatic void model_commit();
        int idx;
        idx = int'(m_addr >> 2);
        m_err = (m_addr % 4 != 0) || (idx >= DEPTH);
        m_rdata = 32'd0;
        if (!m_err) begin
            if (m_we) begin
                for (int b = 0; b < 4; b++)
                    if (m_be[b]) m_mem[idx][8*b +: 8] = m_wdata[8*b +: 8];
            end else begin
                m_rdata = m_mem[idx];
            end
        end
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_pend = 1'b0;
            m_age  = 0;
        end else if (!m_pend) begin
            if (req_valid) begin
                m_pend  = 1'b1;
                m_age   = 0;
                m_we    = req_we;
                m_addr  = req_addr;
                m_wdata = req_wdata;
                m_be    = req_be;
                m_accepts++;
                if (LAT == 0) model_commit();
            end
        end else if (m_age >= LAT) begin
            if (rsp_ready) begin
                m_pend = 1'b0;
                m_dones++;
            end
        end else begin
            m_age++;
            if (m_age == LAT) model_commit();
        end
    end

    // Per-cycle comparison of every DUT output against the model.
    always @(posedge clk) begin
        bit vis;
        #1;
        if (reset) begin
            vis = m_pend && (m_age >= LAT);
            check("req_ready", 32'(req_ready), 32'(!m_pend));
            check("busy", 32'(busy), 32'(m_pend));
            check("rsp_valid", 32'(rsp_valid), 32'(vis));
            check("rsp_rdata", rsp_rdata, vis ? m_rdata : 32'd0);
            check("rsp_err", 32'(rsp_err), 32'(vis && m_err));
        end
    end

    task automatic wait_accept(input int n);
        int k = 0;
        while (m_accepts == n && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (m_accepts == n) fail_now("accept_timeout");
    endtask

    task automatic wait_done(input int d);
        int k = 0;
        while (m_dones == d && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (m_dones == d) fail_now("done_timeout");
    endtask

    task automatic txn(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] be, input bit chk_lit, input logic [31:0] exp_rd,
                       input bit exp_err, input bit chk_lat);
        int n, d, k;
        n = m_accepts;
        d = m_dones;
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        req_be    = be;
        rsp_ready = 1'b1;
        wait_accept(n);
        req_valid = 1'b0;
        req_addr  = $urandom;
        req_wdata = $urandom;
        req_be    = 4'($urandom);
        req_we    = ~we;
        k = 1;
        while (!rsp_valid && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (chk_lat) check("latency", 32'(k), 32'(LAT + 1));
        if (chk_lit) begin
            check("lit_rdata", rsp_rdata, exp_rd);
            check("lit_err", 32'(rsp_err), 32'(exp_err));
        end
        wait_done(d);
    endtask

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n, d;
        repeat (2) @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rdata", rsp_rdata, 32'd0);
        check("rst_err", 32'(rsp_err), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        reset = 1'b1;

        for (int w = 0; w < DEPTH; w++) txn(1'b1, 32'(w * 4), 32'd0, 4'hF, 1'b0, 32'd0, 1'b0, 1'b0);

        txn(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 1'b1, 32'd0, 1'b0, 1'b1);
        txn(1'b0, 32'h10, 32'd0, 4'h0, 1'b1, 32'hDEADBEEF, 1'b0, 1'b1);

        txn(1'b1, 32'h20, 32'h11223344, 4'hF, 1'b0, 32'd0, 1'b0, 1'b0);
        txn(1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, 1'b1, 32'd0, 1'b0, 1'b0);
        txn(1'b0, 32'h20, 32'd0, 4'hF, 1'b1, 32'h11BB33DD, 1'b0, 1'b0);
        txn(1'b1, 32'h20, 32'hFFFFFFFF, 4'h0, 1'b1, 32'd0, 1'b0, 1'b0);
        txn(1'b0, 32'h20, 32'd0, 4'h0, 1'b1, 32'h11BB33DD, 1'b0, 1'b0);

        txn(1'b0, 32'h13, 32'd0, 4'hF, 1'b1, 32'd0, 1'b1, 1'b0);
        txn(1'b1, 32'h400, 32'hCAFEF00D, 4'hF, 1'b1, 32'd0, 1'b1, 1'b0);
        txn(1'b0, 32'h0, 32'd0, 4'hF, 1'b1, 32'd0, 1'b0, 1'b0);

        // Backpressure with a second request waiting behind the held response.
        n = m_accepts;
        d = m_dones;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h10; rsp_ready = 1'b0;
        wait_accept(n);
        req_we = 1'b1; req_addr = 32'h24; req_wdata = 32'h12345678; req_be = 4'hF;
        while (!rsp_valid && m_age < LAT + 5) @(negedge clk);
        for (int c = 0; c < 5; c++) begin
            check("bp_valid", 32'(rsp_valid), 32'd1);
            check("bp_rdata", rsp_rdata, 32'hDEADBEEF);
            check("bp_req_ready", 32'(req_ready), 32'd0);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        check("bp_idle_after_hs", 32'(req_ready), 32'd1);
        @(negedge clk);
        check("bp_accept_next", 32'(busy), 32'd1);
        req_valid = 1'b0;
        wait_done(d + 1);
        txn(1'b0, 32'h24, 32'd0, 4'h0, 1'b1, 32'h12345678, 1'b0, 1'b0);

        // Reset while the store is still waiting: it must never reach storage.
        n = m_accepts;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h40; req_wdata = 32'h55AA55AA; req_be = 4'hF;
        wait_accept(n);
        req_valid = 1'b0;
        reset = 1'b0;
        #1;
        check("midrst_req_ready", 32'(req_ready), 32'd1);
        check("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_rdata", rsp_rdata, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        txn(1'b0, 32'h40, 32'd0, 4'hF, 1'b1, 32'd0, 1'b0, 1'b0);

        // Randomized traffic; the per-cycle compare does all the checking here.
        for (int c = 0; c < 800; c++) begin
            int sel;
            @(negedge clk);
            sel       = int'($urandom_range(0, 9));
            req_valid = ($urandom_range(0, 1) == 1);
            req_we    = ($urandom_range(0, 1) == 1);
            req_wdata = $urandom;
            req_be    = 4'($urandom);
            rsp_ready = ($urandom_range(0, 9) < 7);
            if (sel < 8)       req_addr = 32'($urandom_range(0, 63) * 4);
            else if (sel == 8) req_addr = 32'($urandom_range(0, 255) * 4 + $urandom_range(1, 3));
            else               req_addr = 32'($urandom_range(256, 511) * 4);
        end
        @(negedge clk);
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        for (int k = 0; k < 20 && m_pend; k++) @(negedge clk);
        if (m_pend) fail_now("drain_timeout");

        // Zero-latency instance: back-to-back misaligned loads every other cycle.
        @(negedge clk);
        l0_req_valid = 1'b1; l0_req_we = 1'b0; l0_req_addr = 32'h3; l0_rsp_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            check("l0_req_ready", 32'(l0_req_ready), 32'(c % 2 == 0));
            check("l0_rsp_valid", 32'(l0_rsp_valid), 32'(c % 2 == 1));
            check("l0_rsp_err", 32'(l0_rsp_err), 32'(c % 2 == 1));
            check("l0_rsp_rdata", l0_rsp_rdata, 32'd0);
            @(negedge clk);
        end
        l0_req_valid = 1'b0;
        repeat (2) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Memory-side responder for the core's data-memory load/store port, with a req/rsp valid-ready handshake.
- Accepts one request at a time, holds it for a programmable number of wait cycles, then performs the word access with byte enables and returns a response.
- Gives the pipeline a realistic multi-cycle memory target, and gives the UVM environment a stall source for checking StallF/StallD behaviour.

Parameters:
DEPTH_WORDS, 256, number of 32-bit words in storage; word index is req_addr[31:2]
LATENCY, 2, wait cycles between request acceptance and the memory access (0 allowed, max 15)

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-low reset
req_valid  input  1  request present
req_ready  output  1  responder can accept a request
req_we  input  1  1 = store, 0 = load
req_addr  input  32  byte address
req_wdata  input  32  store data
req_be  input  4  byte enables; bit i covers wdata[8i+7:8i]
rsp_valid  output  1  response present
rsp_ready  input  1  requester accepts the response
rsp_rdata  output  32  load data; 0 for stores and errors
rsp_err  output  1  misaligned or out-of-range request
busy  output  1  transaction in flight (state != IDLE)

Behaviour:
- Reset (reset low, asynchronous):
  - state=IDLE, wait counter=0, captured request cleared.
  - Outputs: req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, busy=0.
  - Storage contents are not cleared by reset; simulation initial value is 0.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - Accept on a rising edge with req_valid&req_ready; capture we/addr/wdata/be.
  - Next state is WAIT with counter=LATENCY-1 if LATENCY>0, else RESP directly.
- WAIT:
  - req_ready=0.
  - Counter decrements each cycle.
  - At the edge where counter==0: perform the access and enter RESP.
- Access, performed on the edge entering RESP:
  - Error check: err = (addr[1:0]!=0) | (addr[31:2] >= DEPTH_WORDS).
  - Store with no error: write each byte whose be bit is set; untouched bytes keep their value. rsp_rdata=0.
  - Load with no error: rsp_rdata = full word; be is ignored for loads.
  - err=1: no write, rsp_rdata=0, rsp_err=1.
  - req_be=0 on a store is a legal no-op that still responds, with err=0.
- RESP:
  - rsp_valid=1; rsp_rdata and rsp_err held stable until the handshake.
  - On rsp_valid&rsp_ready at an edge: go to IDLE, rsp_valid=0, rsp_rdata=0, rsp_err=0.
  - req_ready stays 0 until the state is back in IDLE; no request accepted in the handshake cycle.
- Latency: with the accept edge in cycle 0, rsp_valid is first high in cycle LATENCY+1.
- Throughput: with rsp_ready tied 1, one transaction per LATENCY+2 cycles.
- Requester-side changes to req_* after acceptance have no effect; the captured copy is used.
- Reset mid-operation:
  - Reset during WAIT discards the pending request; a store that has not reached its commit edge is never written.
  - Reset during RESP drops the response.
  - Data already committed to storage is retained.
- busy=1 in WAIT and RESP.

Test Plan:
- LATENCY=2, rsp_ready=1:
  - Store addr 0x10, data 0xDEADBEEF, be=4'hF accepted in cycle 0 -> rsp_valid high in cycle 3 with rsp_err=0, rsp_rdata=0.
  - Load 0x10 accepted in cycle 4 -> rsp_valid in cycle 7 with rsp_rdata=0xDEADBEEF.
- Byte enables: word 0x20 = 0x11223344, then store 0xAABBCCDD with be=4'b0101 -> subsequent load returns 0x11BB33DD.
- Backpressure: load response with rsp_ready=0 for 5 cycles:
  - rsp_valid and rsp_rdata held constant, req_ready=0 throughout.
  - req_valid asserted meanwhile is not accepted until the cycle after the rsp handshake.
- Errors:
  - Load at 0x13 -> rsp_err=1, rsp_rdata=0.
  - Store at 0x400 with DEPTH_WORDS=256 -> rsp_err=1, and a subsequent load of word 0 is unchanged.
- Reset mid-WAIT: store 0x55AA55AA to 0x40 accepted, reset pulsed low in cycle 1 -> outputs at reset values immediately; a later load of 0x40 returns the old value (0).
- LATENCY=0: load accepted in cycle 0 -> rsp_valid in cycle 1; with rsp_ready=1, back-to-back loads accepted in cycles 0, 2, 4.
